// File: rtl/ahb_sram_pkg.sv
// Shared types and decode helpers for the AHB-Lite SRAM controller.
// Lane masks assume four byte lanes forming one 32-bit word.
package ahb_sram_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_WSTL = 3'd3,
        ST_ERR1 = 3'd4,
        ST_ERR2 = 3'd5
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [2:0] hsize,
                                                       input logic [1:0] addr_lo);
        logic [NUM_LANES-1:0] m;
        case (hsize)
            HSIZE_BYTE: m = 4'b0001 << addr_lo;
            HSIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

    // Oversized transfers and any access not aligned to its own size.
    function automatic logic misaligned(input logic [2:0] hsize,
                                        input logic [1:0] addr_lo);
        logic bad;
        bad = (hsize > HSIZE_WORD)
            || ((hsize == HSIZE_HALF) && addr_lo[0])
            || ((hsize == HSIZE_WORD) && (addr_lo != 2'b00));
        return bad;
    endfunction

endpackage

// File: rtl/ahb_sram_lane_dec.sv
// Combinational byte-lane decode: transfer size and low address bits
// produce the per-bank enable mask and an unsupported-transfer flag.
module ahb_sram_lane_dec
    import ahb_sram_pkg::*;
#(
    parameter int LANES = NUM_LANES
) (
    input  logic [2:0]       hsize,
    input  logic [1:0]       addr_lo,
    output logic [LANES-1:0] mask,
    output logic             err
);

    always_comb begin
        err  = misaligned(hsize, addr_lo);
        mask = lane_mask(hsize, addr_lo);
        if (err) begin
            mask = '0;
        end
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave presenting four byte-wide SRAM banks as one 32-bit memory.
// Reads are issued combinationally in the address phase; writes in the data phase.
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int LANES      = NUM_LANES
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [8*LANES-1:0]    HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [8*LANES-1:0]    HRDATA,
    output logic [LANES-1:0]      sram_csb,
    output logic                  sram_web,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [8*LANES-1:0]    sram_din,
    input  logic [8*LANES-1:0]    sram_dout,
    output state_e                dbg_state
);

    localparam int DATA_W = 8 * LANES;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [LANES-1:0]      mask_q, mask_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic [LANES-1:0]      dec_mask;
    logic                  dec_err;
    logic [ADDR_WIDTH-1:0] haddr_idx;
    logic                  trans_active;
    logic                  valid;
    logic                  conflict;
    logic                  stall;
    logic                  accept;
    logic                  rd_issue;
    logic                  unused_haddr;

    ahb_sram_lane_dec #(.LANES(LANES)) u_lane_dec (
        .hsize   (HSIZE),
        .addr_lo (HADDR[1:0]),
        .mask    (dec_mask),
        .err     (dec_err)
    );

    assign haddr_idx    = HADDR[ADDR_WIDTH+1:2];
    assign unused_haddr = ^HADDR[31:ADDR_WIDTH+2];
    assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign valid        = HSEL && HREADY && trans_active;

    // A read arriving during a write data phase cannot share the single
    // address bus with the write strobes, so it waits one cycle.
    assign conflict = (state_q == ST_WR) && HSEL && trans_active && !HWRITE;
    assign stall    = (state_q == ST_ERR1) || conflict;
    assign accept   = valid && !stall;
    assign rd_issue = accept && !HWRITE && !dec_err && !HRESET;

    always_comb begin
        state_d = ST_IDLE;
        idx_d   = idx_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (conflict) begin
            state_d = ST_WSTL;
        end else if (accept) begin
            if (dec_err) begin
                state_d = ST_ERR1;
            end else if (HWRITE) begin
                state_d = ST_WR;
                idx_d   = haddr_idx;
                mask_d  = dec_mask;
            end else begin
                state_d = ST_RD;
            end
        end
        if (rd_issue) begin
            rdata_d = sram_dout;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    // Reset gates the strobes directly so an in-flight write is dropped
    // before the banks sample on the falling edge.
    always_comb begin
        sram_csb  = '1;
        sram_web  = 1'b1;
        sram_addr = '0;
        sram_din  = '0;
        if (!HRESET) begin
            if (state_q == ST_WR) begin
                sram_csb  = ~mask_q;
                sram_web  = 1'b0;
                sram_addr = idx_q;
                sram_din  = HWDATA;
            end else if (rd_issue) begin
                sram_csb  = '0;
                sram_addr = haddr_idx;
            end
        end
    end

    always_comb begin
        HREADYOUT = !stall;
        HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
        HRDATA    = (state_q == ST_RD) ? rdata_q : '0;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl: a per-cycle vector table plus a
// reset-during-read sequence, against a behavioural four-bank SRAM.
module tb_ahb_sram_ctrl;
  import ahb_sram_pkg::*;

  // clock / reset
  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  always #5 hclk = ~hclk;

  logic        hsel, hwrite, hready;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;
  logic [3:0]  sram_csb;
  logic        sram_web;
  logic [12:0] sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;
  state_e      dbg_state;

  ahb_sram_ctrl #(.ADDR_WIDTH(13), .LANES(4)) dut (
    .HCLK      (hclk),
    .HRESET    (hreset),
    .HSEL      (hsel),
    .HWRITE    (hwrite),
    .HREADY    (hready),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HSIZE     (hsize),
    .HWDATA    (hwdata),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .HRDATA    (hrdata),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout),
    .dbg_state (dbg_state)
  );

  // behavioural SRAM banks, sampling on the falling edge
  logic [7:0] mem [0:3][0:8191];
  initial begin
    sram_dout = '0;
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 8192; w++)
        mem[b][w] = 8'h00;
  end
  always @(negedge hclk) begin
    for (int b = 0; b < 4; b++) begin
      if (!sram_csb[b]) begin
        if (!sram_web) mem[b][sram_addr] = sram_din[8*b +: 8];
        else           sram_dout[8*b +: 8] = mem[b][sram_addr];
      end
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic        wr;
    logic        rdy_in;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_rdata;
    logic [3:0]  e_csb;
    logic        e_web;
    logic [12:0] e_addr;
    logic [31:0] e_din;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sel, input logic wr, input logic rdy_in,
                     input logic [1:0] trans, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic e_rdy, input logic e_resp, input logic [31:0] e_rdata,
                     input logic [3:0] e_csb, input logic e_web,
                     input logic [12:0] e_addr, input logic [31:0] e_din);
    vec_t v;
    v = '{sel, wr, rdy_in, trans, size, addr, wdata,
          e_rdy, e_resp, e_rdata, e_csb, e_web, e_addr, e_din};
    vecs.push_back(v);
  endtask

  // shorthands for a quiet bus cycle and for the all-inactive response
  task automatic add_idle(input logic [31:0] wdata, input logic e_rdy, input logic e_resp,
                          input logic [31:0] e_rdata);
    add(0, 0, 1, HTRANS_IDLE, 3'd0, 32'h0, wdata, e_rdy, e_resp, e_rdata,
        4'hF, 1, 13'h0, 32'h0);
  endtask

  task automatic add_quiet(input logic sel, input logic wr, input logic rdy_in,
                           input logic [2:0] size, input logic [31:0] addr);
    add(sel, wr, rdy_in, HTRANS_NONSEQ, size, addr, 32'h0, 1, 0, 32'h0,
        4'hF, 1, 13'h0, 32'h0);
  endtask

  task automatic drive(input vec_t v);
    hsel   = v.sel;
    hwrite = v.wr;
    hready = v.rdy_in;
    htrans = v.trans;
    hsize  = v.size;
    haddr  = v.addr;
    hwdata = v.wdata;
  endtask

  task automatic drive_read(input logic [31:0] addr);
    hsel = 1; hwrite = 0; hready = 1; htrans = HTRANS_NONSEQ; hsize = 3'd2;
    haddr = addr; hwdata = '0;
  endtask

  task automatic drive_idle();
    hsel = 0; hwrite = 0; hready = 1; htrans = HTRANS_IDLE; hsize = 3'd0;
    haddr = '0; hwdata = '0;
  endtask

  initial begin
    drive_idle();

    // word write, idle, read back
    add_idle(32'h0, 1, 0, 32'h0);
    add_quiet(1, 1, 1, 3'd2, 32'h10);
    add(0, 0, 1, HTRANS_IDLE, 3'd0, 32'h0, 32'hDEADBEEF, 1, 0, 32'h0, 4'h0, 0, 13'd4, 32'hDEADBEEF);
    add_idle(32'h0, 1, 0, 32'h0);
    add(1, 0, 1, HTRANS_NONSEQ, 3'd2, 32'h10, 32'h0, 1, 0, 32'h0, 4'h0, 1, 13'd4, 32'h0);
    add_idle(32'h0, 1, 0, 32'hDEADBEEF);
    // byte write into lane 3, read back merged word
    add_quiet(1, 1, 1, 3'd0, 32'h13);
    add(0, 0, 1, HTRANS_IDLE, 3'd0, 32'h0, 32'h5A000000, 1, 0, 32'h0, 4'h7, 0, 13'd4, 32'h5A000000);
    add(1, 0, 1, HTRANS_NONSEQ, 3'd2, 32'h10, 32'h0, 1, 0, 32'h0, 4'h0, 1, 13'd4, 32'h0);
    add_idle(32'h0, 1, 0, 32'h5AADBEEF);
    // read immediately after write: one wait state, then read issued
    add_quiet(1, 1, 1, 3'd2, 32'h20);
    add(1, 0, 1, HTRANS_NONSEQ, 3'd2, 32'h20, 32'h12345678, 0, 0, 32'h0, 4'h0, 0, 13'd8, 32'h12345678);
    add(1, 0, 1, HTRANS_NONSEQ, 3'd2, 32'h20, 32'h0, 1, 0, 32'h0, 4'h0, 1, 13'd8, 32'h0);
    add_idle(32'h0, 1, 0, 32'h12345678);
    // two error transfers, the second accepted in ERR2
    add_quiet(1, 0, 1, 3'd3, 32'h0);
    add_idle(32'h0, 0, 1, 32'h0);
    add(1, 1, 1, HTRANS_NONSEQ, 3'd1, 32'h1, 32'h0, 1, 1, 32'h0, 4'hF, 1, 13'h0, 32'h0);
    add_idle(32'h0, 0, 1, 32'h0);
    add_idle(32'h0, 1, 1, 32'h0);
    add_idle(32'h0, 1, 0, 32'h0);
    // address alias and top word
    add_quiet(1, 1, 1, 3'd2, 32'h8000);
    add(0, 0, 1, HTRANS_IDLE, 3'd0, 32'h0, 32'hCAFEF00D, 1, 0, 32'h0, 4'h0, 0, 13'd0, 32'hCAFEF00D);
    add(1, 0, 1, HTRANS_NONSEQ, 3'd2, 32'h0, 32'h0, 1, 0, 32'h0, 4'h0, 1, 13'd0, 32'h0);
    add(1, 1, 1, HTRANS_NONSEQ, 3'd2, 32'h7FFC, 32'h0, 1, 0, 32'hCAFEF00D, 4'hF, 1, 13'd0, 32'h0);
    add(0, 0, 1, HTRANS_IDLE, 3'd0, 32'h0, 32'hA5A51234, 1, 0, 32'h0, 4'h0, 0, 13'd8191, 32'hA5A51234);
    add(1, 0, 1, HTRANS_NONSEQ, 3'd2, 32'h7FFC, 32'h0, 1, 0, 32'h0, 4'h0, 1, 13'd8191, 32'h0);
    add_idle(32'h0, 1, 0, 32'hA5A51234);
    // back-to-back byte and half writes, then back-to-back reads
    add_quiet(1, 1, 1, 3'd0, 32'h41);
    add(1, 1, 1, HTRANS_NONSEQ, 3'd1, 32'h46, 32'h00007700, 1, 0, 32'h0, 4'hD, 0, 13'h10, 32'h00007700);
    add(0, 0, 1, HTRANS_IDLE, 3'd0, 32'h0, 32'hBEEF0000, 1, 0, 32'h0, 4'h3, 0, 13'h11, 32'hBEEF0000);
    add(1, 0, 1, HTRANS_NONSEQ, 3'd2, 32'h40, 32'h0, 1, 0, 32'h0, 4'h0, 1, 13'h10, 32'h0);
    add(1, 0, 1, HTRANS_NONSEQ, 3'd2, 32'h44, 32'h0, 1, 0, 32'h00007700, 4'h0, 1, 13'h11, 32'h0);
    add_idle(32'h0, 1, 0, 32'hBEEF0000);
    // HREADY low or HSEL low: not a transfer
    add_quiet(1, 0, 0, 3'd2, 32'h10);
    add_idle(32'h0, 1, 0, 32'h0);
    add_quiet(0, 1, 1, 3'd2, 32'h10);
    add_idle(32'h0, 1, 0, 32'h0);

    // reset state, checked while reset is held
    #12;
    check("rst_hreadyout", -1, hreadyout, 1);
    check("rst_hresp",     -1, hresp,     0);
    check("rst_hrdata",    -1, hrdata,    0);
    check("rst_csb",       -1, sram_csb,  4'hF);
    check("rst_web",       -1, sram_web,  1);
    @(posedge hclk); #1;
    hreset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #3;
      check("hreadyout", i, hreadyout, vecs[i].e_rdy);
      check("hresp",     i, hresp,     vecs[i].e_resp);
      check("hrdata",    i, hrdata,    vecs[i].e_rdata);
      check("sram_csb",  i, sram_csb,  vecs[i].e_csb);
      check("sram_web",  i, sram_web,  vecs[i].e_web);
      check("sram_addr", i, sram_addr, vecs[i].e_addr);
      check("sram_din",  i, sram_din,  vecs[i].e_din);
      @(posedge hclk); #1;
    end

    // reset asserted during a read data phase takes effect without a clock
    drive_read(32'h10);
    #3;
    check("rr_csb_addr", 100, sram_csb, 4'h0);
    @(posedge hclk); #1;
    drive_read(32'h10);
    #3;
    check("rr_hrdata", 101, hrdata, 32'h5AADBEEF);
    #3;
    hreset = 1'b1;
    #1;
    check("rr_rst_hrdata",    102, hrdata,    0);
    check("rr_rst_hreadyout", 102, hreadyout, 1);
    check("rr_rst_csb",       102, sram_csb,  4'hF);
    check("rr_rst_state",     102, dbg_state, ST_IDLE);
    @(posedge hclk); #1;
    hreset = 1'b0;
    drive_read(32'h20);
    #3;
    check("rr_post_csb",  103, sram_csb,  4'h0);
    check("rr_post_addr", 103, sram_addr, 13'd8);
    @(posedge hclk); #1;
    drive_idle();
    #3;
    check("rr_post_hrdata", 104, hrdata, 32'h12345678);
    @(posedge hclk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_ctrl.md
# ahb_sram_ctrl

AHB-Lite slave controller that sequences four 8-bit × 8192-word SRAM macros as one 32-bit, byte-laned, 32 KB memory. It sits between the AHB interconnect and the SRAM banks. It converts address/data-phase AHB transfers into SRAM chip-select, write-enable, address and data strobes. It resolves the read-after-write port conflict with one wait state and returns two-cycle ERROR responses for unsupported transfers.

## Interface
- ADDR_WIDTH, 13: SRAM word-address width; memory spans 4·2^ADDR_WIDTH bytes.
- LANES, 4: byte lanes (SRAM banks); data width 8·LANES.
- HCLK  in  1  clock; SRAM clk0 of every bank tied to HCLK.
- HRESET  in  1  reset; one clock, asynchronous, active-high.
- HSEL, HWRITE, HREADY  in  1  AHB select, direction, bus-ready.
- HADDR  in  32  AHB address; only [ADDR_WIDTH+1:0] decoded, upper bits ignored (alias).
- HTRANS  in  2  AHB transfer type; HSIZE  in  3  transfer size.
- HWDATA  in  32  write data (data phase).
- HREADYOUT  out  1  slave ready; HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data (registered).
- sram_csb  out  LANES  per-bank active-low chip select.
- sram_web  out  1  shared active-low write enable.
- sram_addr  out  ADDR_WIDTH  shared word address.
- sram_din  out  32  lane i on bits [8i+7:8i].
- sram_dout  in  32  bank read data, same lane mapping.

## Operation
- Valid transfer: HSEL & HREADY & HTRANS[1]. Word index = HADDR[14:2], byte = HADDR[1:0].
- Lane mask: HSIZE 0 → 1<<HADDR[1:0]; HSIZE 1 → 0011 (HADDR[1]=0) or 1100; HSIZE 2 → 1111.
- ERROR cases: HSIZE>2, or half with HADDR[0]=1, or word with HADDR[1:0]≠0. No SRAM access is issued.
- States: IDLE, RD, WR, WSTL, ERR1, ERR2.
- Read, address phase: the bank access is driven combinationally in the same cycle: sram_csb=0000, sram_web=1, sram_addr=index. The SRAM samples on negedge. sram_dout is captured into rdata_q at the next posedge. Next state RD.
- Write, address phase: index, mask and HWRITE are registered. Next state WR.
- WR, write data phase: sram_csb=~mask, sram_web=0, sram_addr=registered index, sram_din=HWDATA.
- Read-after-write conflict: in WR, if HSEL & HTRANS[1] & ~HWRITE, then HREADYOUT=0 and the next state is WSTL. The write is still committed this cycle.
- WSTL: HREADYOUT=1, no write is re-issued. The pending read address phase is driven to SRAM as a normal read.
- Write-after-write and write-after-read need no stall.
- Error path: ERR1 drives HREADYOUT=0, HRESP=1. ERR2 drives HREADYOUT=1, HRESP=1. In ERR2, a new valid transfer is accepted normally.
- Outside any access: sram_csb=1111, sram_web=1, sram_din=0.
- HRDATA = rdata_q in RD, otherwise 0. The full word is always returned regardless of HSIZE.
- Transfers with HSEL=0 or HTRANS IDLE/BUSY: OKAY, zero wait; state goes to IDLE after the current data phase.

## Timing
- Read: address phase N, data phase N+1, HRDATA valid throughout N+1. Zero wait states.
- Write: SRAM write strobes in data phase N+1; bank updated at negedge of N+1. Zero wait states.
- Read immediately after write: exactly one wait state, on the write's data phase.
- ERROR: exactly two data-phase cycles.
- Reset: asynchronously forces state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, rdata_q=0, sram_csb=1111, sram_web=1.
- Reset asserted mid-transfer aborts it. A write whose strobes were removed before the negedge is not performed.

## Structure
- Package ahb_sram_pkg holds:
  - the state enum;
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ;
  - HSIZE encodings;
  - lane-mask and alignment-check functions.
- Sub-module ahb_sram_lane_dec: combinational HSIZE/HADDR[1:0] → lane mask plus error flag.
- The FSM, registered address phase and rdata_q live in the top module.

## Test plan
- Word write 0xDEADBEEF to 0x10, then idle, then read 0x10.
  - Write data phase: sram_addr=4, sram_csb=0000, sram_web=0.
  - Read returns HRDATA=0xDEADBEEF, no wait states.
- After the previous test, byte write 0x5A at 0x13 with HWDATA[31:24]=0x5A.
  - sram_csb=0111.
  - Word read of 0x10 returns 0x5AADBEEF.
- Write 0x12345678 to 0x20 immediately followed by read of 0x20.
  - HREADYOUT=0 for one cycle in the write data phase.
  - Read returns 0x12345678.
- HSIZE=3 at 0x0, then halfword at 0x1.
  - Each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1).
  - sram_csb stays 1111 throughout.
- Write 0xCAFEF00D to 0x8000, then read 0x0000.
  - Returns 0xCAFEF00D (alias).
  - Write to 0x7FFC then read 0x7FFC gives sram_addr=8191.
- Assert HRESET during a read data phase.
  - HRDATA=0, HREADYOUT=1, sram_csb=1111 immediately, without waiting for HCLK.
  - After release, the next read works.
